// File: rtl/crc8_serial_if.sv
// Handshake bundle for the bit-serial CRC block: serial bit input channel
// and finished-CRC output channel, each with valid/ready.
interface crc8_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_crc;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_crc
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_crc
  );
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC generator: an XOR feedback shift register fed MSB-first
// through a valid/ready stream, presenting each frame's CRC on a valid/ready port.
module crc8_serial #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   POLY  = 'h07,
  parameter logic [WIDTH-1:0]   INIT  = '0
) (
  input  logic          clk,
  input  logic          rst,
  crc8_serial_if.slave  bus,
  output logic          busy,
  output logic [15:0]   bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_crc;
  logic [WIDTH-1:0] r_out_crc;
  logic [15:0]      r_bit_cnt;

  logic             w_accept;
  logic             w_release;
  logic             w_fb;
  logic [WIDTH-1:0] w_crc_next;

  assign bus.in_ready  = (r_state != DONE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_crc   = r_out_crc;
  assign busy          = (r_state == SHIFT);
  assign bit_cnt       = r_bit_cnt;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_release  = bus.out_valid && bus.out_ready;
  assign w_fb       = r_crc[WIDTH-1] ^ bus.in_bit;
  assign w_crc_next = {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = bus.in_last ? DONE : SHIFT;
      SHIFT:   if (w_accept && bus.in_last) w_state_next = DONE;
      DONE:    if (w_release) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_crc     <= INIT;
      r_out_crc <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_crc <= w_crc_next;
        // The first bit of a frame restarts the count; otherwise saturate.
        if (r_state == IDLE)
          r_bit_cnt <= 16'd1;
        else if (r_bit_cnt != 16'hFFFF)
          r_bit_cnt <= r_bit_cnt + 16'd1;
        if (bus.in_last)
          r_out_crc <= w_crc_next;
      end
      // out_crc keeps its value past the handshake; only the shifter reloads.
      if (w_release)
        r_crc <= INIT;
    end
  end

endmodule
